// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared op/state encodings and counter sizing for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    localparam int MDU_WIDTH = 32;

    function automatic int mdu_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mul_div_unit_cond_negate.sv
// rtl/mul_div_unit_cond_negate.sv - two's-complement conditional negate, y = neg ? -x : x
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_neg ? (~i_x + WIDTH'(1)) : i_x;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiply / restoring divide with HI/LO registers
// Divider datapath is compiled only when MDU_DIV_EN is defined.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = mdu_cnt_w(WIDTH);

    mdu_state_t         r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_neg_q;

    mdu_op_t            w_op;
    logic               w_op_valid, w_accept, w_signed, w_is_mul, w_is_div_op, w_run_op;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next, w_step, w_prod;
    logic [WIDTH-1:0]   w_res_hi, w_res_lo;

    assign w_op        = mdu_op_t'(op);
    assign w_op_valid  = (op < 3'd6);
    assign w_accept    = (r_state == IDLE) && start && w_op_valid;
    assign w_signed    = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_is_mul    = (w_op == OP_MULT) || (w_op == OP_MULTU);
    assign w_is_div_op = (w_op == OP_DIV)  || (w_op == OP_DIVU);
    assign w_last      = (r_cnt == CNT_W'(1));

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_signed & a[WIDTH-1]), .i_x(a), .o_y(w_a_mag));
    cond_negate #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_signed & b[WIDTH-1]), .i_x(b), .o_y(w_b_mag));

    // Multiply: multiplier sits in the low half and is consumed LSB-first as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    logic               r_is_div, r_neg_r, r_b_zero;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH:0]   w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quot, w_rem;

    // Restoring divide: remainder in the high half, quotient bits shift into the low half.
    assign w_div_shift = {r_acc, 1'b0};
    assign w_div_diff  = w_div_shift[2*WIDTH:WIDTH] - {1'b0, r_opnd};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[2*WIDTH-1:WIDTH], w_div_shift[WIDTH-1:1], 1'b0}
                       : {w_div_diff[WIDTH-1:0],        w_div_shift[WIDTH-1:1], 1'b1};
    assign w_step      = r_is_div ? w_div_next : w_mul_next;
    assign w_run_op    = w_is_mul || w_is_div_op;

    cond_negate #(.WIDTH(WIDTH)) u_neg_quot (.i_neg(r_neg_q), .i_x(w_step[WIDTH-1:0]),       .o_y(w_quot));
    cond_negate #(.WIDTH(WIDTH)) u_neg_rem  (.i_neg(r_neg_r), .i_x(w_step[2*WIDTH-1:WIDTH]), .o_y(w_rem));
`else
    assign w_step   = w_mul_next;
    assign w_run_op = w_is_mul;
`endif

    cond_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.i_neg(r_neg_q), .i_x(w_step), .o_y(w_prod));

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (r_is_div) begin
            if (r_b_zero) begin
                w_res_hi = r_a;
                w_res_lo = {WIDTH{1'b1}};
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_run_op ? RUN : DONE;
            RUN:     if (w_last)   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a      <= '0;
`endif
        end else if (w_accept) begin
            if (w_run_op) begin
                r_cnt   <= CNT_W'(WIDTH);
                r_neg_q <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                if (w_is_div_op) begin
                    r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                    r_opnd <= w_b_mag;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                    r_opnd <= w_a_mag;
                end
            end
            if (w_op == OP_MTHI) r_hi <= a;
            if (w_op == OP_MTLO) r_lo <= a;
`ifdef MDU_DIV_EN
            r_is_div <= w_is_div_op;
            r_neg_r  <= w_signed & a[WIDTH-1];
            r_b_zero <= (b == '0);
            r_a      <= a;
`endif
        end else if (r_state == RUN) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign ready = (r_state == IDLE);
    assign done  = (r_state == DONE);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and randomized checks of mul_div_unit against an arithmetic model
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         ready, done;
    logic [W-1:0] hi, lo;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [31:0]  m_hi = '0;
    logic [31:0]  m_lo = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Architectural result of one op; lat is cycles from the start cycle to the done cycle.
    task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] hi_in, input logic [31:0] lo_in,
                         output logic [31:0] hi_o, output logic [31:0] lo_o, output int lat);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        hi_o = hi_in;
        lo_o = lo_in;
        lat  = 1;
        sa   = av;
        sb   = bv;
        case (o)
            3'd0: begin
                sp = longint'($signed(av)) * longint'($signed(bv));
                {hi_o, lo_o} = sp;
                lat = W + 1;
            end
            3'd1: begin
                up = {32'b0, av} * {32'b0, bv};
                {hi_o, lo_o} = up;
                lat = W + 1;
            end
`ifdef MDU_DIV_EN
            3'd2: begin
                lat = W + 1;
                if (bv == 0) begin
                    lo_o = 32'hFFFF_FFFF; hi_o = av;
                end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    lo_o = 32'h8000_0000; hi_o = 32'h0;
                end else begin
                    lo_o = sa / sb; hi_o = sa % sb;
                end
            end
            3'd3: begin
                lat = W + 1;
                if (bv == 0) begin
                    lo_o = 32'hFFFF_FFFF; hi_o = av;
                end else begin
                    lo_o = av / bv; hi_o = av % bv;
                end
            end
`endif
            3'd4: hi_o = av;
            3'd5: lo_o = av;
            default: ;
        endcase
    endtask

    // Issue one op; optionally re-pulse start with a different op at cycle poke (0 = never).
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input int poke, input string tag);
        logic [31:0] eh, el;
        int          elat, lat;
        bit          seen, rdy_bad;
        model(o, av, bv, m_hi, m_lo, eh, el, elat);
        check({tag, "_ready_idle"}, 64'(ready), 64'd1);
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 5));
        lat = 1; seen = 0; rdy_bad = 0;
        while (!seen && lat <= 100) begin
            if (ready) rdy_bad = 1;
            if (done) seen = 1;
            else begin
                if (lat == poke) start = 1'b1;
                tick();
                start = 1'b0;
                lat++;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_ready_busy"}, 64'(rdy_bad), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        tick();
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_ready_after"}, 64'(ready), 64'd1);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        bit          any_done;
        bit          rdy_drop;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        tick(); tick();
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        tick();

        issue(3'd1, 32'hFFFF_FFFF, 32'h2, 0, "multu_max");
        issue(3'd0, 32'hFFFF_FFFD, 32'h7, 0, "mult_neg");
        issue(3'd5, 32'h0000_AAAA, 32'h0, 0, "mtlo_pre");
        issue(3'd4, 32'h0000_1234, 32'h0, 0, "mthi");
        issue(3'd5, 32'h0000_5678, 32'h0, 0, "mtlo");
        issue(3'd2, 32'hFFFF_FFF9, 32'h2, 0, "div_neg");
        issue(3'd3, 32'h0000_0064, 32'h0, 0, "divu_zero");
        issue(3'd2, 32'hFFFF_FF9C, 32'h0, 0, "div_zero");
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        issue(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 0, "div_mixed");
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5, "multu_ignore");

        start = 1'b1; op = 3'd7; a = 32'hDEAD_BEEF; b = 32'h1;
        any_done = 0; rdy_drop = 0;
        tick();
        start = 1'b0;
        repeat (6) begin
            if (done) any_done = 1;
            if (!ready) rdy_drop = 1;
            tick();
        end
        check("op7_no_done", 64'(any_done), 64'd0);
        check("op7_ready", 64'(rdy_drop), 64'd0);
        check("op7_hi", 64'(hi), 64'(m_hi));
        check("op7_lo", 64'(lo), 64'(m_lo));

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            else if (ro >= 3'd2 && $urandom_range(0, 1) == 1) rb = $urandom_range(1, 100);
            issue(ro, ra, rb, 0, "rand");
        end

        issue(3'd4, 32'h0BAD_F00D, 32'h0, 0, "mthi_pre_rst");
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        any_done = 0;
        repeat (40) begin
            if (done) any_done = 1;
            tick();
        end
        check("midrst_no_done", 64'(any_done), 64'd0);
        check("midrst_hi_hold", 64'(hi), 64'd0);
        issue(3'd1, 32'd6, 32'd7, 0, "post_rst_multu");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
